// File: rtl/conv_mac_sequencer_if.sv
// conv_mac_sequencer_if: start/abort request, operand window, shared multiplier link and results.
interface conv_mac_sequencer_if;
    logic                   start;
    logic                   abort;
    logic [2:0][2:0][3:0]   pixels;
    logic [2:0][2:0][4:0]   filter_x;
    logic [2:0][2:0][4:0]   filter_y;
    logic signed [4:0]      mult_a;
    logic signed [4:0]      mult_b;
    logic signed [9:0]      mult_product;
    logic                   busy;
    logic                   done;
    logic signed [12:0]     conv_x;
    logic signed [12:0]     conv_y;
    logic [12:0]            magnitude;

    modport master (
        output start, abort, pixels, filter_x, filter_y, mult_product,
        input  mult_a, mult_b, busy, done, conv_x, conv_y, magnitude
    );

    modport slave (
        input  start, abort, pixels, filter_x, filter_y, mult_product,
        output mult_a, mult_b, busy, done, conv_x, conv_y, magnitude
    );
endinterface

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: time-shares one external 5x5 signed multiplier across both 3x3 kernel passes.
module conv_mac_sequencer (
    input logic clk,
    input logic rst,
    conv_mac_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC_X, MAC_Y, DONE} state_t;
    state_t              r_state, w_next;
    logic [3:0]          r_tap;
    logic signed [12:0]  r_acc, r_x_hold, r_conv_x, r_conv_y;
    logic [12:0]         r_mag;
    logic [8:0][3:0]     r_pix;
    logic [8:0][4:0]     r_fx, r_fy;
    logic                w_mac, w_last;
    logic signed [12:0]  w_sum, w_abs_x, w_abs_y;

    assign w_mac   = r_state == MAC_X || r_state == MAC_Y;
    assign w_last  = r_tap == 4'd8;
    assign w_sum   = r_acc + 13'(bus.mult_product);
    assign w_abs_x = r_x_hold[12] ? -r_x_hold : r_x_hold;
    assign w_abs_y = w_sum[12] ? -w_sum : w_sum;
    // Flattened latches make row-major tap k=r*3+c a direct index
    assign bus.mult_a    = w_mac ? {1'b0, r_pix[r_tap]} : '0;
    assign bus.mult_b    = r_state == MAC_X ? r_fx[r_tap] : r_state == MAC_Y ? r_fy[r_tap] : '0;
    assign bus.busy      = r_state != IDLE;
    assign bus.done      = r_state == DONE;
    assign bus.conv_x    = r_conv_x;
    assign bus.conv_y    = r_conv_y;
    assign bus.magnitude = r_mag;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? MAC_X : IDLE;
            MAC_X:   w_next = bus.abort ? IDLE : w_last ? MAC_Y : MAC_X;
            MAC_Y:   w_next = bus.abort ? IDLE : w_last ? DONE : MAC_Y;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_tap    <= '0;
            r_acc    <= '0;
            r_x_hold <= '0;
            r_conv_x <= '0;
            r_conv_y <= '0;
            r_mag    <= '0;
            r_pix    <= '0;
            r_fx     <= '0;
            r_fy     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.start) begin
                r_pix <= bus.pixels;
                r_fx  <= bus.filter_x;
                r_fy  <= bus.filter_y;
                r_acc <= '0;
                r_tap <= '0;
            end else if (w_mac && !bus.abort) begin
                r_acc <= w_last ? '0 : w_sum;
                r_tap <= w_last ? '0 : r_tap + 4'd1;
                if (w_last && r_state == MAC_X)
                    r_x_hold <= w_sum;
                if (w_last && r_state == MAC_Y) begin
                    r_conv_x <= r_x_hold;
                    r_conv_y <= w_sum;
                    r_mag    <= 13'(w_abs_x + w_abs_y);
                end
            end
        end
    end
endmodule
